// File: rtl/maze_walker_if.sv
// Handshake bundle for maze_walker.
// Carries maze/command inputs and direction/result outputs.
interface maze_walker_if #(
    parameter int STEP_W = 10
);
    logic              in_valid1;
    logic [1:0]        in;
    logic              in_valid2;
    logic              in_data;
    logic              out_valid1;
    logic [2:0]        out;
    logic              out_valid2;
    logic [STEP_W-1:0] out_data;

    modport master (
        output in_valid1, in, in_valid2, in_data,
        input  out_valid1, out, out_valid2, out_data
    );

    modport slave (
        input  in_valid1, in, in_valid2, in_data,
        output out_valid1, out, out_valid2, out_data
    );
endinterface

// File: rtl/maze_walker.sv
// Wall-following maze walker: loads a SIZE x SIZE maze, walks to
// the far corner one move per cycle, streams moves and a step count.
module maze_walker #(
    parameter int SIZE      = 17,
    parameter int STEP_W    = 10,
    parameter int MAX_STEPS = 1022
) (
    input  logic         clk,
    input  logic         rst,
    maze_walker_if.slave bus
);
    localparam int N  = SIZE * SIZE;
    localparam int CW = $clog2(SIZE);
    localparam int IW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(MAX_STEPS);

    typedef enum logic [2:0] {
        IDLE, LOAD, WAIT_CMD, WALK, TRAP, DONE
    } state_t;

    state_t            state_q;
    logic [1:0]        maze_q [N];
    logic [IW-1:0]     idx_q;
    logic [CW-1:0]     row_q;
    logic [CW-1:0]     col_q;
    logic [1:0]        head_q;
    logic              hand_q;
    logic              fail_q;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_d;
    logic              out_valid1_q;
    logic [2:0]        out_q;
    logic              out_valid2_q;
    logic [STEP_W-1:0] out_data_q;

    logic              wr_en;
    logic [IW-1:0]     wr_idx;

    always_comb begin
        wr_en  = 1'b0;
        wr_idx = '0;
        unique case (state_q)
            IDLE, WAIT_CMD: wr_en = bus.in_valid1;
            LOAD: begin
                wr_en  = bus.in_valid1;
                wr_idx = idx_q;
            end
            default: wr_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) maze_q[i] <= 2'd0;
        end else if (wr_en) begin
            maze_q[wr_idx] <= bus.in;
        end
    end

    // Neighbour per absolute direction: 0 right, 1 down, 2 left, 3 up
    logic [CW-1:0] nr [4];
    logic [CW-1:0] nc [4];
    logic [3:0]    inb;
    logic [3:0]    opn;
    logic [3:0]    trp;
    logic [IW-1:0] nidx;
    logic [1:0]    code;
    logic          corner;

    always_comb begin
        for (int d = 0; d < 4; d++) begin
            nr[d] = row_q;
            nc[d] = col_q;
        end
        nc[0] = col_q + 1'b1;
        nr[1] = row_q + 1'b1;
        nc[2] = col_q - 1'b1;
        nr[3] = row_q - 1'b1;
        inb = {row_q != '0, col_q != '0,
               row_q != LAST, col_q != LAST};
        opn    = '0;
        trp    = '0;
        nidx   = '0;
        code   = '0;
        corner = 1'b0;
        for (int d = 0; d < 4; d++) begin
            nidx = inb[d] ?
                IW'(nr[d]) * IW'(SIZE) + IW'(nc[d]) : '0;
            code = maze_q[nidx];
            corner = (nr[d] == '0 && nc[d] == '0) ||
                     (nr[d] == LAST && nc[d] == LAST);
            opn[d] = inb[d] && (corner || code != 2'd1);
            trp[d] = !corner && code == 2'd2;
        end
    end

    logic [1:0] pdir [4];
    logic       found;
    logic [1:0] mdir;
    logic       goal_hit;

    // Probe order: preferred side, straight, other side, back
    always_comb begin
        pdir[0] = hand_q ? head_q + 2'd3 : head_q + 2'd1;
        pdir[1] = head_q;
        pdir[2] = hand_q ? head_q + 2'd1 : head_q + 2'd3;
        pdir[3] = head_q + 2'd2;
        found = 1'b0;
        mdir  = head_q;
        for (int k = 3; k >= 0; k--) begin
            if (opn[pdir[k]]) begin
                found = 1'b1;
                mdir  = pdir[k];
            end
        end
        goal_hit = found && nr[mdir] == LAST && nc[mdir] == LAST;
        step_d   = step_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            head_q       <= '0;
            hand_q       <= 1'b0;
            fail_q       <= 1'b0;
            step_q       <= '0;
            out_valid1_q <= 1'b0;
            out_q        <= 3'd0;
            out_valid2_q <= 1'b0;
            out_data_q   <= '0;
        end else begin
            out_valid1_q <= 1'b0;
            out_q        <= 3'd0;
            out_valid2_q <= 1'b0;
            out_data_q   <= '0;
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid1) begin
                        idx_q   <= IW'(1);
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (bus.in_valid1) begin
                        if (idx_q == LAST_IDX) state_q <= WAIT_CMD;
                        else idx_q <= idx_q + 1'b1;
                    end
                end
                WAIT_CMD: begin
                    if (bus.in_valid1) begin
                        idx_q   <= IW'(1);
                        state_q <= LOAD;
                    end else if (bus.in_valid2) begin
                        hand_q  <= bus.in_data;
                        row_q   <= '0;
                        col_q   <= '0;
                        head_q  <= 2'd0;
                        step_q  <= '0;
                        fail_q  <= 1'b0;
                        state_q <= WALK;
                    end
                end
                WALK: begin
                    out_valid1_q <= 1'b1;
                    step_q       <= step_d;
                    if (found) begin
                        out_q  <= {1'b0, mdir};
                        row_q  <= nr[mdir];
                        col_q  <= nc[mdir];
                        head_q <= mdir;
                    end else begin
                        out_q <= 3'd4;
                    end
                    if (goal_hit) begin
                        state_q <= DONE;
                    end else if (step_d == STEP_MAX) begin
                        fail_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (found && trp[mdir]) begin
                        state_q <= TRAP;
                    end
                end
                TRAP: begin
                    out_valid1_q <= 1'b1;
                    out_q        <= 3'd4;
                    step_q       <= step_d;
                    if (step_d == STEP_MAX) begin
                        fail_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= WALK;
                    end
                end
                DONE: begin
                    out_valid2_q <= 1'b1;
                    out_data_q   <= fail_q ? '1 : step_q;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.out_valid1 = out_valid1_q;
    assign bus.out        = out_q;
    assign bus.out_valid2 = out_valid2_q;
    assign bus.out_data   = out_data_q;
endmodule
